// File: rtl/cov_hit_collector.sv
// Coverage hit collector: per-point saturating hit counters, covered mask/total,
// and a frozen snapshot dump streamed over a valid/ready port.
//
// Ports:
//   clock, reset           - rising-edge clock, async active-low reset
//   cov_en, hit            - counting enable and per-point hit pulses
//   clear                  - zero counters, mask and lost_cnt; abort dump
//   dump_req, busy         - start a snapshot dump / dump in progress
//   out_valid, out_ready   - dump beat handshake
//   out_idx, out_count     - beat point index and its counter value
//   out_last               - beat for the final point
//   covered_mask/_total    - points with a nonzero counter, and their count
//   lost_cnt               - saturating count of enabled-hit cycles during a dump
module cov_hit_collector #(
    parameter int NUM_POINTS = 13,
    parameter int CNT_W      = 16,
    parameter int IDX_W      = $clog2(NUM_POINTS),
    parameter int TOT_W      = $clog2(NUM_POINTS + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cov_en,
    input  logic [NUM_POINTS-1:0] hit,
    input  logic                  clear,
    input  logic                  dump_req,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDX_W-1:0]      out_idx,
    output logic [CNT_W-1:0]      out_count,
    output logic                  out_last,
    output logic [NUM_POINTS-1:0] covered_mask,
    output logic [TOT_W-1:0]      covered_total,
    output logic [CNT_W-1:0]      lost_cnt
);

    localparam logic [0:0]       S_IDLE   = 1'b0;
    localparam logic [0:0]       S_DUMP   = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_POINTS - 1);

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt     [NUM_POINTS];
    logic [CNT_W-1:0] cnt_inc [NUM_POINTS];
    logic [IDX_W-1:0] nxt_idx;
    logic             any_hit;

    // Counter values after this cycle's hits; also feeds the first dump beat
    // so a hit coinciding with dump_req shows up in the snapshot.
    always_comb begin
        for (int i = 0; i < NUM_POINTS; i++) begin
            cnt_inc[i] = cnt[i];
            if (cov_en && hit[i] && cnt[i] != CNT_MAX)
                cnt_inc[i] = cnt[i] + CNT_W'(1);
        end
    end

    assign nxt_idx = out_idx + IDX_W'(1);
    assign any_hit = cov_en && (|hit);
    assign busy    = (state == S_DUMP);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_idx   <= '0;
            out_count <= '0;
            lost_cnt  <= '0;
            for (int i = 0; i < NUM_POINTS; i++) cnt[i] <= '0;
        end else if (clear) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_idx   <= '0;
            out_count <= '0;
            lost_cnt  <= '0;
            for (int i = 0; i < NUM_POINTS; i++) cnt[i] <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    for (int i = 0; i < NUM_POINTS; i++) cnt[i] <= cnt_inc[i];
                    if (dump_req) begin
                        state     <= S_DUMP;
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        out_idx   <= '0;
                        out_count <= cnt_inc[0];
                    end
                end
                S_DUMP: begin
                    if (any_hit && lost_cnt != CNT_MAX)
                        lost_cnt <= lost_cnt + CNT_W'(1);
                    if (out_valid && out_ready) begin
                        if (out_last) begin
                            state     <= S_IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            out_idx   <= nxt_idx;
                            out_count <= cnt[nxt_idx];
                            out_last  <= (nxt_idx == LAST_IDX);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        covered_total = '0;
        for (int i = 0; i < NUM_POINTS; i++) begin
            covered_mask[i] = |cnt[i];
            covered_total   = covered_total + TOT_W'(covered_mask[i]);
        end
    end

endmodule

// File: tb/tb_cov_hit_collector.sv
// Testbench for cov_hit_collector: random and directed stimulus against a
// behavioural model; dump beats checked by a queue-based scoreboard.
module tb_cov_hit_collector;

    localparam int NP   = 13;
    localparam int CW   = 4;
    localparam int IW   = $clog2(NP);
    localparam int TW   = $clog2(NP + 1);
    localparam int MAXC = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          cov_en;
    logic [NP-1:0] hit;
    logic          clear;
    logic          dump_req;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_idx;
    logic [CW-1:0] out_count;
    logic          out_last;
    logic [NP-1:0] covered_mask;
    logic [TW-1:0] covered_total;
    logic [CW-1:0] lost_cnt;

    cov_hit_collector #(
        .NUM_POINTS(NP),
        .CNT_W     (CW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .cov_en       (cov_en),
        .hit          (hit),
        .clear        (clear),
        .dump_req     (dump_req),
        .busy         (busy),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_idx      (out_idx),
        .out_count    (out_count),
        .out_last     (out_last),
        .covered_mask (covered_mask),
        .covered_total(covered_total),
        .lost_cnt     (lost_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        int idx;
        int cnt;
        bit last;
    } beat_t;

    beat_t q[$];
    int    m_cnt[NP];
    int    m_lost;
    bit    m_dump;
    int    m_rem;
    int    m_beat;
    int    n_tot;
    int    n_pass;

    function automatic void chk(string nm, int act, int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endfunction

    function automatic void model_zero();
        for (int i = 0; i < NP; i++) m_cnt[i] = 0;
        m_lost = 0;
        m_dump = 0;
        m_rem  = 0;
        m_beat = 0;
        q.delete();
    endfunction

    // Spec-level behaviour applied at each rising edge using the driven inputs.
    function automatic void model_edge();
        if (!reset) return;
        if (clear) begin
            model_zero();
        end else if (m_dump) begin
            if (cov_en && (|hit) && m_lost < MAXC) m_lost++;
            if (out_ready) begin
                m_rem--;
                m_beat++;
                if (m_rem == 0) m_dump = 0;
            end
        end else begin
            for (int i = 0; i < NP; i++)
                if (cov_en && hit[i] && m_cnt[i] < MAXC) m_cnt[i]++;
            if (dump_req) begin
                for (int i = 0; i < NP; i++)
                    q.push_back('{idx: i, cnt: m_cnt[i], last: (i == NP - 1)});
                m_dump = 1;
                m_rem  = NP;
                m_beat = 0;
            end
        end
    endfunction

    task automatic cyc();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    // Monitor: status outputs every cycle, dump beats against the queue.
    always @(negedge clock) begin
        int exp_tot;
        logic [NP-1:0] em;
        exp_tot = 0;
        for (int i = 0; i < NP; i++) begin
            em[i] = (m_cnt[i] != 0);
            if (m_cnt[i] != 0) exp_tot++;
        end
        chk("busy", int'(busy), int'(m_dump));
        chk("out_valid", int'(out_valid), int'(m_dump));
        chk("lost_cnt", int'(lost_cnt), m_lost);
        chk("covered_mask", int'(covered_mask), int'(em));
        chk("covered_total", int'(covered_total), exp_tot);
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_beat", 1, 0);
            end else begin
                chk("beat_idx", int'(out_idx), q[0].idx);
                chk("beat_count", int'(out_count), q[0].cnt);
                chk("beat_last", int'(out_last), int'(q[0].last));
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic run_dump(input int mode);
        int k;
        dump_req = 1'b1;
        out_ready = 1'b1;
        cyc();
        dump_req = 1'b0;
        k = 0;
        while (m_dump && k < 200) begin
            out_ready = (mode == 0) ? 1'b1 : 1'($urandom % 2);
            cyc();
            k++;
        end
        if (m_dump) chk("dump_timeout", 1, 0);
    endtask

    task automatic wait_beat(input int b);
        int k;
        k = 0;
        while (m_dump && m_beat != b && k < 100) begin
            cyc();
            k++;
        end
        chk("reach_beat", m_beat, b);
    endtask

    initial begin
        n_tot    = 0;
        n_pass   = 0;
        model_zero();
        reset    = 1'b0;
        cov_en   = 1'b0;
        hit      = '0;
        clear    = 1'b0;
        dump_req = 1'b0;
        out_ready = 1'b0;
        repeat (3) cyc();
        reset = 1'b1;
        cyc();
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_out_count", int'(out_count), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_total", int'(covered_total), 0);

        // basic count and dump
        cov_en = 1'b1;
        repeat (3) begin
            hit = NP'(1);
            cyc();
            hit = '0;
            cyc();
        end
        hit[12] = 1'b1;
        cyc();
        hit = '0;
        cyc();
        chk("basic_total", int'(covered_total), 2);
        dump_req  = 1'b1;
        out_ready = 1'b1;
        cyc();
        dump_req = 1'b0;
        repeat (NP - 1) cyc();
        chk("basic_busy_last", int'(busy), 1);
        cyc();
        chk("basic_busy_done", int'(busy), 0);

        // saturation and enable
        hit = NP'(1) << 1;
        repeat (20) cyc();
        cov_en = 1'b0;
        hit = NP'(1) << 2;
        repeat (5) cyc();
        hit = '0;
        cov_en = 1'b1;
        chk("sat_mask1", int'(covered_mask[1]), 1);
        chk("dis_mask2", int'(covered_mask[2]), 0);

        // backpressure and lost hits
        dump_req  = 1'b1;
        out_ready = 1'b0;
        cyc();
        dump_req = 1'b0;
        for (int k = 0; k < 60 && m_dump; k++) begin
            out_ready = 1'(k % 2);
            hit = (k < 4) ? (NP'(1) << 3) : '0;
            cyc();
        end
        hit = '0;
        chk("lost4", int'(lost_cnt), 4);
        run_dump(0);

        // clear mid-dump
        dump_req  = 1'b1;
        out_ready = 1'b1;
        cyc();
        dump_req = 1'b0;
        wait_beat(5);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("clr_valid", int'(out_valid), 0);
        chk("clr_busy", int'(busy), 0);
        chk("clr_lost", int'(lost_cnt), 0);
        chk("clr_total", int'(covered_total), 0);
        run_dump(0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            cov_en    = 1'($urandom % 4 != 0);
            hit       = NP'($urandom) & NP'($urandom);
            dump_req  = 1'($urandom % 15 == 0);
            out_ready = 1'($urandom % 2);
            clear     = 1'($urandom % 70 == 0);
            cyc();
        end
        clear    = 1'b0;
        dump_req = 1'b0;
        hit      = '0;
        for (int k = 0; k < 40 && m_dump; k++) begin
            out_ready = 1'b1;
            cyc();
        end
        run_dump(1);

        // async reset mid-dump
        dump_req  = 1'b1;
        out_ready = 1'b1;
        cyc();
        dump_req = 1'b0;
        wait_beat(7);
        out_ready = 1'b0;
        #2;
        reset = 1'b0;
        model_zero();
        #1;
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_idx", int'(out_idx), 0);
        cyc();
        reset = 1'b1;
        cyc();
        cov_en    = 1'b1;
        hit       = NP'(1) << 4;
        dump_req  = 1'b1;
        out_ready = 1'b1;
        cyc();
        hit = '0;
        dump_req = 1'b0;
        chk("same_cyc_mask4", int'(covered_mask[4]), 1);
        repeat (NP + 1) cyc();

        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
